// File: rtl/ras_pkg.sv
// Shared types and helpers for the return-address-stack spill path.
// Holds the spill FSM encoding, word size and count-width function.
package ras_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPILL_WR,
    S_SPILL_POP,
    S_FILL_RD,
    S_FILL_PUSH
  } spill_state_t;

  localparam int WORD_BYTES = 4;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ras_spill_ctrl.sv
// Spills the oldest RAS entries to a memory-backed LIFO and refills them.
// One entry per episode pass; IDLE re-evaluates thresholds after each.
module ras_spill_ctrl
  import ras_pkg::*;
#(
  parameter int              DATA_WIDTH  = 32,
  parameter int              ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] SPILL_BASE = 32'h0000_F000,
  parameter int              SPILL_DEPTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  over_thresh,
  input  logic                  under_thresh,
  input  logic                  full,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] dout_bottom,
  output logic                  push_bottom,
  output logic                  pop_bottom,
  output logic [DATA_WIDTH-1:0] din_bottom,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [cnt_width(SPILL_DEPTH)-1:0] spill_cnt,
  output logic                  busy,
  output logic                  spill_overflow
);

  localparam int CW = cnt_width(SPILL_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(SPILL_DEPTH);

  spill_state_t state_q, state_d;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  ovf_q, ovf_d;

  logic [ADDR_WIDTH-1:0] off_cur;
  logic [ADDR_WIDTH-1:0] off_top;

  assign off_cur = ADDR_WIDTH'(cnt_q) * ADDR_WIDTH'(WORD_BYTES);
  assign off_top = ADDR_WIDTH'(cnt_q - CW'(1)) * ADDR_WIDTH'(WORD_BYTES);

  logic do_spill;
  logic do_ovf;
  logic do_fill;

  assign do_spill = ena & over_thresh & ~empty & (cnt_q < DEPTH_C);
  assign do_ovf   = ena & over_thresh & (cnt_q == DEPTH_C);
  assign do_fill  = ena & under_thresh & ~full & (cnt_q != '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    din_d   = din_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (do_spill) begin
          state_d = S_SPILL_WR;
          wdata_d = dout_bottom;
          addr_d  = SPILL_BASE + off_cur;
          we_d    = 1'b1;
        end else if (do_ovf) begin
          ovf_d = 1'b1;
        end else if (do_fill) begin
          state_d = S_FILL_RD;
          addr_d  = SPILL_BASE + off_top;
          we_d    = 1'b0;
        end
      end
      S_SPILL_WR: begin
        if (mem_ack) begin
          cnt_d   = cnt_q + CW'(1);
          state_d = S_SPILL_POP;
        end
      end
      S_SPILL_POP: state_d = S_IDLE;
      S_FILL_RD: begin
        if (mem_ack) begin
          din_d   = mem_rdata;
          cnt_d   = cnt_q - CW'(1);
          state_d = S_FILL_PUSH;
        end
      end
      S_FILL_PUSH: state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      din_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      din_q   <= din_d;
      ovf_q   <= ovf_d;
    end
  end

  // Stack pulses come straight from state so they can never overlap.
  assign pop_bottom     = (state_q == S_SPILL_POP);
  assign push_bottom    = (state_q == S_FILL_PUSH);
  assign mem_req        = (state_q == S_SPILL_WR) | (state_q == S_FILL_RD);
  assign mem_we         = we_q;
  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;
  assign din_bottom     = din_q;
  assign spill_cnt      = cnt_q;
  assign busy           = (state_q != S_IDLE);
  assign spill_overflow = ovf_q;

endmodule

// File: tb/tb_ras_spill_ctrl.sv
// Randomized bench for ras_spill_ctrl against a queue-based stack/memory model.
// The model tracks on-chip stack, memory LIFO and the program's view of returns.
module tb_ras_spill_ctrl;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [31:0] BASE = 32'h0000_F000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ena = 1'b1;
  logic          over_thresh = 1'b0;
  logic          under_thresh = 1'b0;
  logic          full = 1'b0;
  logic          empty = 1'b1;
  logic [DW-1:0] dout_bottom = '0;
  logic          push_bottom;
  logic          pop_bottom;
  logic [DW-1:0] din_bottom;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic [CW-1:0] spill_cnt;
  logic          busy;
  logic          spill_overflow;

  always #5 clk = ~clk;

  ras_spill_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .SPILL_BASE (BASE),
    .SPILL_DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ena           (ena),
    .over_thresh   (over_thresh),
    .under_thresh  (under_thresh),
    .full          (full),
    .empty         (empty),
    .dout_bottom   (dout_bottom),
    .push_bottom   (push_bottom),
    .pop_bottom    (pop_bottom),
    .din_bottom    (din_bottom),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .spill_cnt     (spill_cnt),
    .busy          (busy),
    .spill_overflow(spill_overflow)
  );

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] stk[$];
  logic [31:0] memq[$];
  logic [31:0] golden[$];
  logic [31:0] mem_arr[logic [31:0]];
  logic [31:0] wr_addrs[$];
  logic [31:0] wr_data[$];
  logic [31:0] rd_addrs[$];
  logic [31:0] pushed[$];

  int hi_th = 1000;
  int lo_th = -1;
  int cap = 64;
  bit force_full = 0;
  int wait_cfg = 0;
  int wait_left = 0;
  int idle_ack = 2;
  bit prog_en = 0;
  bit ena_rand = 0;

  bit in_txn = 0;
  logic [31:0] hold_addr, hold_wdata;
  logic hold_we;
  bit exp_pop = 0, exp_push = 0;
  logic [31:0] exp_din;
  bit pend_pop = 0, pend_push = 0, pend_call = 0, pend_ret = 0;
  logic [31:0] pend_val, call_val;
  bit commit_wr = 0, commit_rd = 0;
  logic [31:0] commit_val;
  int req_cycles = 0, pops = 0, pushes = 0;

  task automatic drive_inputs();
    over_thresh  = (stk.size() >= hi_th);
    under_thresh = (stk.size() <= lo_th);
    full         = (stk.size() >= cap) || force_full;
    empty        = (stk.size() == 0);
    dout_bottom  = (stk.size() > 0) ? stk[0] : 32'h0;
  endtask

  task automatic clear_logs();
    wr_addrs.delete(); wr_data.delete();
    rd_addrs.delete(); pushed.delete();
    req_cycles = 0; pops = 0; pushes = 0;
  endtask

  task automatic tick();
    logic [31:0] ea;
    logic [31:0] ew;
    int r;
    @(posedge clk);
    if (rst) begin
      stk.delete(); memq.delete(); golden.delete(); mem_arr.delete();
      in_txn = 0; exp_pop = 0; exp_push = 0;
    end else begin
      if (pend_pop && stk.size() > 0) void'(stk.pop_front());
      if (pend_push) stk.push_front(pend_val);
      if (commit_wr) memq.push_back(commit_val);
      if (commit_rd && memq.size() > 0) void'(memq.pop_back());
      if (pend_call) begin
        stk.push_back(call_val); golden.push_back(call_val);
      end
      if (pend_ret) begin
        void'(stk.pop_back()); void'(golden.pop_back());
      end
    end
    pend_pop = 0; pend_push = 0; pend_call = 0; pend_ret = 0;
    commit_wr = 0; commit_rd = 0;
    #1;
    n_total++;
    if (spill_cnt !== CW'(memq.size()))
      $display("FAIL spill_cnt: got %0d expected %0d", spill_cnt, memq.size());
    else n_pass++;
    n_total++;
    if (pop_bottom !== exp_pop)
      $display("FAIL pop_bottom: got %b expected %b", pop_bottom, exp_pop);
    else n_pass++;
    n_total++;
    if (push_bottom !== exp_push)
      $display("FAIL push_bottom: got %b expected %b", push_bottom, exp_push);
    else n_pass++;
    if (exp_push) begin
      n_total++;
      if (din_bottom !== exp_din)
        $display("FAIL din_bottom: got %h expected %h", din_bottom, exp_din);
      else n_pass++;
    end
    pend_pop = (pop_bottom === 1'b1);
    pend_push = (push_bottom === 1'b1);
    pend_val = din_bottom;
    if (pend_pop) pops++;
    if (pend_push) begin pushes++; pushed.push_back(din_bottom); end
    exp_pop = 0; exp_push = 0;
    mem_ack = 1'b0;
    mem_rdata = $urandom;
    if (mem_req === 1'b1 && !rst) begin
      req_cycles++;
      if (!in_txn) begin
        in_txn = 1;
        hold_addr = mem_addr; hold_we = mem_we; hold_wdata = mem_wdata;
        wait_left = (wait_cfg < 0) ? int'($urandom_range(0, 3)) : wait_cfg;
        if (mem_we) begin
          wr_addrs.push_back(mem_addr); wr_data.push_back(mem_wdata);
          ea = BASE + 32'(4 * memq.size());
          ew = (stk.size() > 0) ? stk[0] : 32'hxxxx_xxxx;
          n_total++;
          if (mem_wdata !== ew)
            $display("FAIL spill_wdata: got %h expected %h", mem_wdata, ew);
          else n_pass++;
        end else begin
          rd_addrs.push_back(mem_addr);
          ea = BASE + 32'(4 * (memq.size() - 1));
        end
        n_total++;
        if (mem_addr !== ea)
          $display("FAIL mem_addr: got %h expected %h", mem_addr, ea);
        else n_pass++;
      end else begin
        n_total++;
        if ({mem_addr, mem_we, mem_wdata} !== {hold_addr, hold_we, hold_wdata})
          $display("FAIL req_hold: got %h/%b/%h expected %h/%b/%h",
                   mem_addr, mem_we, mem_wdata, hold_addr, hold_we, hold_wdata);
        else n_pass++;
      end
      if (wait_left == 0) begin
        mem_ack = 1'b1;
        in_txn = 0;
        if (hold_we) begin
          mem_arr[hold_addr] = hold_wdata;
          commit_wr = 1; commit_val = hold_wdata; exp_pop = 1;
        end else begin
          mem_rdata = mem_arr.exists(hold_addr) ? mem_arr[hold_addr] : 32'hBAD0_BAD0;
          exp_din = (memq.size() > 0) ? memq[$] : 32'hxxxx_xxxx;
          exp_push = 1; commit_rd = 1;
        end
      end else begin
        wait_left--;
      end
    end else begin
      in_txn = 0;
      mem_ack = (idle_ack == 2) ? 1'($urandom_range(0, 1)) : (idle_ack == 1);
    end
    if (prog_en && !rst && !busy) begin
      r = $urandom_range(0, 3);
      if (r == 0 && stk.size() < cap - 1) begin
        pend_call = 1; call_val = $urandom;
      end else if (r == 1 && stk.size() >= 2) begin
        n_total++;
        if (stk[$] !== golden[$])
          $display("FAIL ret_value: got %h expected %h", stk[$], golden[$]);
        else n_pass++;
        pend_ret = 1;
      end
    end
    if (ena_rand) ena = ($urandom_range(0, 3) != 0);
    drive_inputs();
  endtask

  task automatic reset_all();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    hi_th = 1000; lo_th = -1; cap = 64; force_full = 0;
    ena = 1'b1; prog_en = 0; ena_rand = 0; idle_ack = 2;
    clear_logs();
  endtask

  task automatic load(input int n, input logic [31:0] seed);
    for (int i = 0; i < n; i++) begin
      stk.push_back(seed + 32'(i));
      golden.push_back(seed + 32'(i));
    end
    drive_inputs();
  endtask

  task automatic test_reset();
    idle_ack = 1;
    rst = 1'b1;
    tick(); tick();
    n_total++;
    if ({mem_req, mem_we, push_bottom, pop_bottom, busy, spill_overflow} !== 6'b0)
      $display("FAIL reset_ctrl: got %b expected 000000",
               {mem_req, mem_we, push_bottom, pop_bottom, busy, spill_overflow});
    else n_pass++;
    n_total++;
    if ({mem_addr, mem_wdata, din_bottom} !== 96'h0)
      $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, din_bottom});
    else n_pass++;
    n_total++;
    if (spill_cnt !== '0)
      $display("FAIL reset_cnt: got %0d expected 0", spill_cnt);
    else n_pass++;
    rst = 1'b0;
    idle_ack = 2;
  endtask

  task automatic test_single_spill();
    reset_all();
    wait_cfg = 2;
    stk.push_back(32'h1000_0040); golden.push_back(32'h1000_0040);
    load(2, 32'h2);
    hi_th = 3;
    drive_inputs();
    for (int i = 0; i < 12; i++) tick();
    n_total++;
    if (req_cycles != 3) $display("FAIL single_req_cycles: got %0d expected 3", req_cycles);
    else n_pass++;
    n_total++;
    if (wr_addrs.size() != 1 || wr_addrs[0] !== 32'h0000_F000)
      $display("FAIL single_addr: got %0d writes first %h expected 1 at F000",
               wr_addrs.size(), wr_addrs[0]);
    else n_pass++;
    n_total++;
    if (wr_data[0] !== 32'h1000_0040)
      $display("FAIL single_wdata: got %h expected 10000040", wr_data[0]);
    else n_pass++;
    n_total++;
    if (pops != 1) $display("FAIL single_pops: got %0d expected 1", pops);
    else n_pass++;
    n_total++;
    if (spill_cnt !== CW'(1)) $display("FAIL single_cnt: got %0d expected 1", spill_cnt);
    else n_pass++;
  endtask

  task automatic test_lifo_fill();
    reset_all();
    wait_cfg = 0;
    load(1, 32'hA); load(1, 32'hB); load(1, 32'hC);
    hi_th = 2;
    drive_inputs();
    for (int i = 0; i < 10; i++) tick();
    n_total++;
    if (spill_cnt !== CW'(2)) $display("FAIL lifo_spills: got %0d expected 2", spill_cnt);
    else n_pass++;
    hi_th = 1000; lo_th = 3;
    clear_logs();
    drive_inputs();
    for (int i = 0; i < 20; i++) tick();
    n_total++;
    if (rd_addrs.size() != 2 || rd_addrs[0] !== 32'h0000_F004 || rd_addrs[1] !== 32'h0000_F000)
      $display("FAIL lifo_addrs: got %0d reads %h,%h expected F004,F000",
               rd_addrs.size(), rd_addrs[0], rd_addrs[1]);
    else n_pass++;
    n_total++;
    if (pushed.size() != 2 || pushed[0] !== 32'hB || pushed[1] !== 32'hA)
      $display("FAIL lifo_data: got %h,%h expected B,A", pushed[0], pushed[1]);
    else n_pass++;
    n_total++;
    if (req_cycles != 2 || spill_cnt !== '0)
      $display("FAIL lifo_done: got req %0d cnt %0d expected 2/0", req_cycles, spill_cnt);
    else n_pass++;
    n_total++;
    if (stk.size() != 3 || stk[0] !== 32'hA || stk[1] !== 32'hB)
      $display("FAIL lifo_order: got %h,%h expected A,B", stk[0], stk[1]);
    else n_pass++;
  endtask

  task automatic test_overflow();
    reset_all();
    wait_cfg = -1;
    load(10, 32'h100);
    hi_th = 1;
    drive_inputs();
    for (int i = 0; i < 40; i++) tick();
    for (int i = 0; i < DEPTH; i++) begin
      n_total++;
      if (wr_addrs[i] !== BASE + 32'(4 * i))
        $display("FAIL ovf_addr%0d: got %h expected %h", i, wr_addrs[i], BASE + 32'(4 * i));
      else n_pass++;
    end
    req_cycles = 0;
    for (int i = 0; i < 10; i++) tick();
    n_total++;
    if (req_cycles != 0 || spill_overflow !== 1'b1)
      $display("FAIL ovf_flag: got req %0d flag %b expected 0/1", req_cycles, spill_overflow);
    else n_pass++;
    hi_th = 1000; ena = 1'b0;
    drive_inputs();
    for (int i = 0; i < 10; i++) tick();
    n_total++;
    if (spill_overflow !== 1'b1)
      $display("FAIL ovf_sticky: got %b expected 1", spill_overflow);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int k;
    reset_all();
    wait_cfg = 6;
    load(5, 32'h500);
    hi_th = 1;
    drive_inputs();
    k = 0;
    while (mem_req !== 1'b1 && k < 10) begin tick(); k++; end
    n_total++;
    if (mem_req !== 1'b1) $display("FAIL rstmid_start: got req %b expected 1", mem_req);
    else n_pass++;
    tick();
    rst = 1'b1;
    tick();
    n_total++;
    if ({mem_req, busy, pop_bottom} !== 3'b000 || spill_cnt !== '0)
      $display("FAIL rstmid_state: got %b cnt %0d expected 000 cnt 0",
               {mem_req, busy, pop_bottom}, spill_cnt);
    else n_pass++;
    rst = 1'b0;
    tick(); tick();
    n_total++;
    if (pops != 0) $display("FAIL rstmid_pop: got %0d expected 0", pops);
    else n_pass++;
  endtask

  task automatic test_blocked_fill();
    reset_all();
    wait_cfg = 1;
    load(4, 32'h700);
    hi_th = 1000; lo_th = 1000;
    drive_inputs();
    for (int i = 0; i < 20; i++) tick();
    n_total++;
    if (req_cycles != 0) $display("FAIL blocked_empty: got %0d req expected 0", req_cycles);
    else n_pass++;
    hi_th = 4; lo_th = -1;
    drive_inputs();
    for (int i = 0; i < 10; i++) tick();
    hi_th = 1000; lo_th = 1000; force_full = 1;
    drive_inputs();
    tick();
    req_cycles = 0;
    for (int i = 0; i < 20; i++) tick();
    n_total++;
    if (req_cycles != 0 || spill_cnt !== CW'(1))
      $display("FAIL blocked_full: got req %0d cnt %0d expected 0/1", req_cycles, spill_cnt);
    else n_pass++;
    force_full = 0; ena = 1'b0;
    drive_inputs();
    for (int i = 0; i < 20; i++) tick();
    n_total++;
    if (req_cycles != 0) $display("FAIL blocked_ena: got %0d req expected 0", req_cycles);
    else n_pass++;
    ena = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    n_total++;
    if (spill_cnt !== '0 || stk.size() != 4 || stk[0] !== 32'h700)
      $display("FAIL blocked_release: got cnt %0d bottom %h expected 0/700", spill_cnt, stk[0]);
    else n_pass++;
  endtask

  task automatic test_random();
    int bad;
    reset_all();
    wait_cfg = -1;
    cap = 16; hi_th = 12; lo_th = 6;
    for (int i = 0; i < 8; i++) begin
      call_val = $urandom;
      stk.push_back(call_val); golden.push_back(call_val);
    end
    prog_en = 1; ena_rand = 1;
    drive_inputs();
    for (int i = 0; i < 3000; i++) tick();
    prog_en = 0; ena_rand = 0; ena = 1'b1;
    hi_th = 1000; lo_th = 1000;
    drive_inputs();
    for (int i = 0; i < 40; i++) tick();
    n_total++;
    if (spill_cnt !== '0) $display("FAIL rand_drain: got %0d expected 0", spill_cnt);
    else n_pass++;
    bad = (stk.size() == golden.size()) ? 0 : 1;
    for (int i = 0; i < stk.size() && i < golden.size(); i++)
      if (stk[i] !== golden[i]) bad++;
    n_total++;
    if (bad != 0)
      $display("FAIL rand_contents: got %0d diffs size %0d expected 0 size %0d",
               bad, stk.size(), golden.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_spill();
    test_lifo_fill();
    test_overflow();
    test_reset();
    test_reset_mid();
    test_blocked_fill();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ras_spill_ctrl.md
Name: ras_spill_ctrl

Overview:
- Memory-side partner of the return-address stack's bottom port (push_bottom/pop_bottom/din_bottom/dout_bottom).
- When the stack reports over_thresh, the controller spills the oldest on-chip entry to a reserved memory region. When the stack reports under_thresh, it refills from that region.
- The memory region is used as a second, LIFO-ordered stack. This gives the RAS effectively unbounded depth without losing any return address.
- Sits between ra_stack and the data-memory arbiter.

Parameters:
- DATA_WIDTH, 32, return-address width.
- ADDR_WIDTH, 32, memory address width.
- SPILL_BASE, 32'h0000_F000, byte address of spill entry 0.
- SPILL_DEPTH, 256, maximum number of entries held in memory.

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- ena, in, 1, permits new spill/fill decisions.
- over_thresh, in, 1, from stack.
- under_thresh, in, 1, from stack.
- full, in, 1, from stack.
- empty, in, 1, from stack.
- dout_bottom, in, DATA_WIDTH, current bottom entry of the stack.
- push_bottom, out, 1, one-cycle pulse that inserts din_bottom at the stack bottom.
- pop_bottom, out, 1, one-cycle pulse that removes the stack bottom.
- din_bottom, out, DATA_WIDTH, refilled value.
- mem_req, out, 1, memory request.
- mem_we, out, 1, 1 = write (spill), 0 = read (fill).
- mem_addr, out, ADDR_WIDTH, byte address.
- mem_wdata, out, DATA_WIDTH, spill data.
- mem_ack, in, 1, request accepted/completed.
- mem_rdata, in, DATA_WIDTH, read data, valid in the ack cycle.
- spill_cnt, out, $clog2(SPILL_DEPTH+1), entries currently in memory.
- busy, out, 1, FSM not in IDLE.
- spill_overflow, out, 1, sticky error flag.

Behaviour:
- Reset: state IDLE; all outputs 0, including spill_cnt, din_bottom, mem_* and spill_overflow.
- Reset mid-transaction: mem_req drops on the next cycle and spilled contents are abandoned, consistent with the stack clearing.

FSM states: IDLE, SPILL_WR, SPILL_POP, FILL_RD, FILL_PUSH.

IDLE, evaluated each cycle in priority order:
1. ena & over_thresh & ~empty & spill_cnt < SPILL_DEPTH → SPILL_WR.
   - Latch mem_wdata = dout_bottom.
   - mem_addr = SPILL_BASE + 4*spill_cnt.
   - mem_we = 1.
2. ena & over_thresh & spill_cnt == SPILL_DEPTH → set spill_overflow (sticky until rst); stay IDLE.
3. ena & under_thresh & ~full & spill_cnt > 0 → FILL_RD.
   - mem_addr = SPILL_BASE + 4*(spill_cnt-1).
   - mem_we = 0.
4. Otherwise stay IDLE.

SPILL_WR:
- mem_req = 1; addr, we and wdata held stable until mem_ack is sampled high.
- On ack: spill_cnt += 1, go to SPILL_POP.
- mem_req is 0 in the cycle after ack.

SPILL_POP:
- pop_bottom = 1 for exactly one cycle.
- Memory is written before the stack entry is removed, so no window exists in which the address is held nowhere.
- Go to IDLE.

FILL_RD:
- mem_req = 1 with mem_we = 0.
- On ack: latch din_bottom = mem_rdata, spill_cnt -= 1, go to FILL_PUSH.

FILL_PUSH:
- push_bottom = 1 for exactly one cycle.
- din_bottom stays stable through the pulse and holds its value afterwards.
- Go to IDLE.

Handshake and latency rules:
- mem_ack may arrive in the same cycle mem_req first asserts; this is the zero-wait case.
- mem_ack is ignored in any state other than SPILL_WR and FILL_RD.
- Per entry with zero-wait memory: 3 cycles (IDLE decide, request/ack, stack pulse). Each wait state adds 1 cycle.
- After every entry the FSM returns to IDLE and re-evaluates. Multi-entry episodes continue until the stack leaves the threshold band.
- Stack thresholds (FILL 48, EMPTY 32) provide hysteresis, so no ping-pong occurs.

ena deasserted mid-operation: the in-flight memory transaction and its stack pulse complete; then the FSM idles.

Other invariants:
- push_bottom and pop_bottom are never asserted together.
- Neither is asserted outside FILL_PUSH / SPILL_POP.
- busy = (state != IDLE).
- Address arithmetic is ADDR_WIDTH wide; spill_cnt never exceeds SPILL_DEPTH and never underflows.

Decomposition:
- Shared package ras_pkg holds:
  - the typedef enum for spill_state_t;
  - localparam WORD_BYTES = 4;
  - the spill-count width function.
- No sub-module. Address generation and count live inline; the FSM and datapath fit in one module.

Test Plan:
1. Reset: assert rst 2 cycles with mem_ack = 1 → all outputs 0, busy = 0, spill_cnt = 0.
2. Single spill: over_thresh = 1, dout_bottom = 32'h1000_0040, ack after 2 wait cycles →
   - mem_req with mem_we = 1, mem_addr = 32'h0000_F000, mem_wdata = 32'h1000_0040 held 3 cycles;
   - then pop_bottom pulses 1 cycle;
   - spill_cnt = 1.
3. LIFO fill: spill A = 32'hA, then B = 32'hB (spill_cnt = 2); drop over_thresh, raise under_thresh, zero-wait memory →
   - read at 32'h0000_F004, returns B, push_bottom with din_bottom = 32'hB;
   - then read at 32'h0000_F000, returns A;
   - spill_cnt = 0 and no further requests.
4. Overflow: SPILL_DEPTH = 4, over_thresh held →
   - 4 spills at F000, F004, F008, F00C;
   - then no mem_req, spill_overflow = 1 and stays 1 until rst.
5. Reset mid-transaction: rst during a SPILL_WR wait state → next cycle mem_req = 0, busy = 0, spill_cnt = 0, no pop_bottom pulse.
6. Blocked fill: under_thresh = 1 with full = 1 or spill_cnt = 0, or ena = 0 → mem_req stays 0 for 20 cycles.
